// File: rtl/code_tally_pkg.sv
// rtl/code_tally_pkg.sv - shared types and constants for the decoder code tally
package code_tally_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_COUNT = 3'd2,
        ST_SCAN  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam int NUM_CODES = 8;
    localparam int CODE_MIN  = 1;
    localparam int CODE_MAX  = 8;
    localparam int SCAN_LEN  = 8;

    function automatic logic is_legal(input logic [3:0] c);
        return (c >= 4'(CODE_MIN)) && (c <= 4'(CODE_MAX));
    endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - clearable up-counter that sticks at all-ones
module sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (inc && (q != '1)) begin
            q <= q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/code_tally.sv
// rtl/code_tally.sv - windowed per-code tally of decoder output with most-frequent-code scan
module code_tally
    import code_tally_pkg::*;
#(
    parameter int CNT_W  = 8,
    parameter int WINDOW = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             code_valid,
    input  logic [3:0]       code,
    input  logic [2:0]       rd_idx,
    output logic [CNT_W-1:0] rd_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic [3:0]       top_code,
    output logic             busy,
    output logic             done
);

    state_t                 state;
    logic [CNT_W-1:0]       samp_cnt;
    logic [2:0]             scan_idx;
    logic [CNT_W-1:0]       max_val;
    logic [3:0]             max_code;
    logic [CNT_W-1:0]       cnt [NUM_CODES];
    logic [NUM_CODES-1:0]   inc;
    logic                   err_inc;
    logic                   clr;
    logic [CNT_W-1:0]       scan_val;
    logic                   scan_win;
    logic [3:0]             nxt_code;

    assign clr = (state == ST_CLEAR);

    always_comb begin
        inc     = '0;
        err_inc = 1'b0;
        if ((state == ST_COUNT) && code_valid) begin
            if (is_legal(code)) begin
                inc[3'(code - 4'd1)] = 1'b1;
            end else begin
                err_inc = 1'b1;
            end
        end
    end

    for (genvar g = 0; g < NUM_CODES; g++) begin : g_cnt
        sat_counter #(.CNT_W(CNT_W)) u_cnt (
            .clk   (clk),
            .rst_n (rst_n),
            .clr   (clr),
            .inc   (inc[g]),
            .q     (cnt[g])
        );
    end

    sat_counter #(.CNT_W(CNT_W)) u_err (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .inc   (err_inc),
        .q     (err_cnt)
    );

    // Strict greater-than keeps the earliest (lowest) code on ties and never lets a zero count win.
    assign scan_val = cnt[scan_idx];
    assign scan_win = (scan_val > max_val);
    assign nxt_code = scan_win ? (4'(scan_idx) + 4'd1) : max_code;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            samp_cnt <= '0;
            scan_idx <= '0;
            max_val  <= '0;
            max_code <= '0;
            top_code <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state <= ST_CLEAR;
                        busy  <= 1'b1;
                    end
                end
                ST_CLEAR: begin
                    samp_cnt <= '0;
                    scan_idx <= '0;
                    max_val  <= '0;
                    max_code <= '0;
                    state    <= ST_COUNT;
                end
                ST_COUNT: begin
                    if (code_valid) begin
                        if (samp_cnt == CNT_W'(WINDOW - 1)) begin
                            state <= ST_SCAN;
                        end else begin
                            samp_cnt <= samp_cnt + CNT_W'(1);
                        end
                    end
                end
                ST_SCAN: begin
                    if (scan_win) begin
                        max_val  <= scan_val;
                        max_code <= nxt_code;
                    end
                    scan_idx <= scan_idx + 3'd1;
                    if (scan_idx == 3'(SCAN_LEN - 1)) begin
                        state    <= ST_DONE;
                        top_code <= nxt_code;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_cnt <= '0;
        end else begin
            rd_cnt <= cnt[rd_idx];
        end
    end

endmodule

// File: tb/tb_code_tally.sv
// tb/tb_code_tally.sv - randomized scoreboard bench for code_tally (wide and narrow-counter instances)
module tb_code_tally;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] start, code_valid, busy, done;
    logic [3:0] code   [2];
    logic [2:0] rd_idx [2];
    logic [3:0] top    [2];
    logic [7:0] rd_cnt_a, err_a;
    logic [1:0] rd_cnt_b, err_b;

    int win  [2] = '{16, 4};
    int maxv [2] = '{255, 3};

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    typedef struct { int id; int cyc; int top; int err; } win_t;
    typedef struct { int id; int cyc; int val; } rd_t;

    win_t       win_q [$];
    rd_t        rd_q  [$];
    logic [3:0] stim_q[$];
    int         model_cnt [2][8];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    code_tally #(.CNT_W(8), .WINDOW(16)) u_a (
        .clk(clk), .rst_n(rst_n), .start(start[0]), .code_valid(code_valid[0]),
        .code(code[0]), .rd_idx(rd_idx[0]), .rd_cnt(rd_cnt_a), .err_cnt(err_a),
        .top_code(top[0]), .busy(busy[0]), .done(done[0])
    );

    code_tally #(.CNT_W(2), .WINDOW(4)) u_b (
        .clk(clk), .rst_n(rst_n), .start(start[1]), .code_valid(code_valid[1]),
        .code(code[1]), .rd_idx(rd_idx[1]), .rd_cnt(rd_cnt_b), .err_cnt(err_b),
        .top_code(top[1]), .busy(busy[1]), .done(done[1])
    );

    function automatic int rdv(int id);
        return (id == 0) ? int'(rd_cnt_a) : int'(rd_cnt_b);
    endfunction

    function automatic int errv(int id);
        return (id == 0) ? int'(err_a) : int'(err_b);
    endfunction

    task automatic check(string name, int act, int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every done must match the oldest pending window; reads are matched by the edge that sampled rd_idx.
    always @(negedge clk) begin
        win_t e;
        rd_t  r;
        if (rst_n) begin
            for (int id = 0; id < 2; id++) begin
                if (done[id] === 1'b1) begin
                    if (win_q.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL unexpected_done: dut %0d pulsed done at cycle %0d with no window pending", id, cyc);
                    end else begin
                        e = win_q.pop_front();
                        check("done_dut", id, e.id);
                        check("done_cycle", cyc, e.cyc);
                        check("top_code", int'(top[id]), e.top);
                        check("err_cnt", errv(id), e.err);
                        check("busy_in_done", int'(busy[id]), 0);
                    end
                end
            end
            if (rd_q.size() > 0 && rd_q[0].cyc == cyc) begin
                r = rd_q.pop_front();
                check("rd_cnt", rdv(r.id), r.val);
            end
        end
    end

    function automatic logic [3:0] rand_code();
        if ($urandom_range(0, 3) == 0) return 4'($urandom_range(0, 15));
        return 4'($urandom_range(1, 3));
    endfunction

    task automatic run_window(int id, int gap_pct, bit poke_scan);
        int t, c, acc, err, best, topc;
        int cnts[8];
        win_t e;
        rd_t  r;

        // start with a legal valid code alongside: that sample must be dropped
        start[id] = 1'b1;
        code_valid[id] = 1'b1;
        code[id] = 4'($urandom_range(1, 8));
        tick();
        t = cyc;
        check("busy_after_start", int'(busy[id]), 1);
        start[id] = 1'b0;
        code_valid[id] = 1'($urandom_range(0, 1));
        code[id] = rand_code();
        tick();

        acc = 0;
        while (acc < win[id]) begin
            if (int'($urandom_range(0, 99)) < gap_pct) begin
                code_valid[id] = 1'b0;
                code[id] = rand_code();
            end else begin
                code_valid[id] = 1'b1;
                code[id] = stim_q[acc];
                acc++;
            end
            tick();
        end
        c = cyc;

        err = 0;
        for (int i = 0; i < 8; i++) cnts[i] = 0;
        foreach (stim_q[i]) begin
            if (stim_q[i] >= 1 && stim_q[i] <= 8) cnts[stim_q[i] - 1]++;
            else err++;
        end
        for (int i = 0; i < 8; i++) if (cnts[i] > maxv[id]) cnts[i] = maxv[id];
        if (err > maxv[id]) err = maxv[id];
        best = 0;
        for (int i = 0; i < 8; i++) if (cnts[i] > best) best = cnts[i];
        topc = 0;
        if (best > 0) begin
            for (int i = 7; i >= 0; i--) if (cnts[i] == best) topc = i + 1;
        end
        for (int i = 0; i < 8; i++) model_cnt[id][i] = cnts[i];
        e.id = id; e.cyc = c + 8; e.top = topc; e.err = err;
        win_q.push_back(e);
        if (c - t + 9 == win[id] + 9 && gap_pct == 0)
            check("window_latency", c + 9 - t + 1, win[id] + 10);

        // samples during SCAN/DONE must be ignored, as must a start pulse during SCAN
        for (int k = 0; k < 10; k++) begin
            code_valid[id] = 1'b1;
            code[id] = rand_code();
            start[id] = poke_scan && (k == 3);
            tick();
        end
        code_valid[id] = 1'b0;
        start[id] = 1'b0;
        tick();
        check("busy_idle", int'(busy[id]), 0);

        for (int i = 0; i < 8; i++) begin
            rd_idx[id] = 3'(i);
            tick();
            r.id = id; r.cyc = cyc; r.val = model_cnt[id][i];
            rd_q.push_back(r);
        end
        tick();
    endtask

    task automatic fill_random(int id);
        stim_q.delete();
        for (int i = 0; i < win[id]; i++) stim_q.push_back(rand_code());
    endtask

    task automatic check_reset_outputs();
        for (int id = 0; id < 2; id++) begin
            check("rst_rd_cnt", rdv(id), 0);
            check("rst_err_cnt", errv(id), 0);
            check("rst_top_code", int'(top[id]), 0);
            check("rst_busy", int'(busy[id]), 0);
            check("rst_done", int'(done[id]), 0);
        end
    endtask

    initial begin
        int j;
        logic [3:0] tmp;
        rd_t r;

        start = '0;
        code_valid = '0;
        for (int i = 0; i < 2; i++) begin
            code[i] = '0;
            rd_idx[i] = '0;
        end
        rst_n = 1'b0;
        tick(); tick(); tick();
        check_reset_outputs();
        rst_n = 1'b1;
        tick();

        // mixed window: 8 x code 2, 5 x code 7, 3 x code 0, shuffled
        stim_q.delete();
        for (int i = 0; i < 8; i++) stim_q.push_back(4'd2);
        for (int i = 0; i < 5; i++) stim_q.push_back(4'd7);
        for (int i = 0; i < 3; i++) stim_q.push_back(4'd0);
        for (int i = stim_q.size() - 1; i > 0; i--) begin
            j = $urandom_range(0, i);
            tmp = stim_q[i]; stim_q[i] = stim_q[j]; stim_q[j] = tmp;
        end
        run_window(0, 0, 1'b0);

        stim_q = '{4'd5, 4'd3, 4'd5, 4'd3};
        run_window(1, 0, 1'b0);
        stim_q = '{4'd0, 4'd9, 4'd15, 4'd12};
        run_window(1, 0, 1'b0);
        stim_q = '{4'd1, 4'd1, 4'd1, 4'd1};
        run_window(1, 0, 1'b0);
        stim_q = '{4'd4, 4'd4, 4'd4, 4'd2};
        run_window(1, 40, 1'b1);

        for (int n = 0; n < 6; n++) begin
            fill_random(0);
            run_window(0, (n % 2) * 30, n == 1);
            fill_random(1);
            run_window(1, (n % 3) * 25, n == 2);
        end

        // reset in the middle of COUNT on the wide instance
        start[0] = 1'b1;
        tick();
        start[0] = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            code_valid[0] = 1'b1;
            code[0] = 4'd3;
            tick();
        end
        code_valid[0] = 1'b0;
        rst_n = 1'b0;
        #1;
        check_reset_outputs();
        tick(); tick();
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            rd_idx[0] = 3'(i);
            tick();
            r.id = 0; r.cyc = cyc; r.val = 0;
            rd_q.push_back(r);
        end
        tick(); tick();
        check("busy_after_reset", int'(busy[0]), 0);

        fill_random(0);
        run_window(0, 20, 1'b0);

        for (int i = 0; i < 5; i++) tick();
        check("pending_windows", win_q.size(), 0);
        check("pending_reads", rd_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/code_tally.md
# code_tally

Downstream consumer of the 2-bit casex select decoder's 4-bit output code. It accumulates a fixed-length window of decoded codes into per-code saturating counters and counts invalid codes separately. At the end of the window it scans the counters to report the most frequent code. It gives the team a synthesizable, observable record of decoder activity for bring-up and regression.

## Interface

**Parameters**
- `CNT_W`, default 8: width of each per-code counter and of the error counter.
- `WINDOW`, default 16: number of accepted samples per tally window. Legal range is 1 to 2^CNT_W-1.

**Ports**
- `clk`, input, 1: single clock. All logic is rising-edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `start`, input, 1: begin a new window. Sampled only in IDLE.
- `code_valid`, input, 1: `code` is valid this cycle.
- `code`, input, 4: decoder output. Codes 1..8 are legal. 0 and 9..15 are invalid.
- `rd_idx`, input, 3: counter select. Index i selects code i+1.
- `rd_cnt`, output, CNT_W: registered value of the counter selected by `rd_idx`.
- `err_cnt`, output, CNT_W: saturating count of invalid codes in the current or last window.
- `top_code`, output, 4: most frequent legal code of the last completed window. 0 if none.
- `busy`, output, 1: high in CLEAR, COUNT and SCAN.
- `done`, output, 1: one-cycle pulse when a window completes.

## Operation

- **FSM states:** IDLE, CLEAR, COUNT, SCAN, DONE.
- **IDLE:** `start` moves to CLEAR. `code_valid` is ignored. Counters, `err_cnt` and `top_code` hold their last values.
- **CLEAR (1 cycle):**
  - All 8 counters, `err_cnt` and the sample counter are zeroed.
  - Then go to COUNT.
  - `code_valid` is ignored in this cycle.
- **COUNT:**
  - Every cycle with `code_valid`=1 is one accepted sample and increments the sample counter.
  - A legal code c increments counter[c-1].
  - An invalid code increments `err_cnt`. Invalid codes still count toward WINDOW.
  - All increments saturate at 2^CNT_W-1. There is no wrap-around.
  - When the WINDOW-th sample is accepted, go to SCAN.
- **SCAN (exactly 8 cycles):**
  - Cycle k compares counter[k] against the running maximum.
  - Replace the maximum only when the count is strictly greater. Ties therefore go to the lowest code.
  - A zero count never wins, so an all-zero window gives `top_code`=0.
- **DONE (1 cycle):** `top_code` is updated, `done`=1, `busy`=0, then go to IDLE.
- `start` asserted in any state other than IDLE is ignored. There is no restart mid-window.
- `rd_cnt` is readable in every state. It reflects the counter contents one cycle after `rd_idx` is sampled.

## Timing

- **Reset values:** state=IDLE, all counters=0, `rd_cnt`=0, `err_cnt`=0, `top_code`=0, `busy`=0, `done`=0.
- **Reset mid-operation:** immediate return to the reset values. Partial windows are discarded and no `done` is issued.
- **Start sequence:** `start` sampled at edge t. CLEAR is active in cycle t+1 with `busy`=1. COUNT begins at cycle t+2.
- **Window completion:** the last sample is accepted at edge c. SCAN runs for cycles c+1..c+8. DONE is in cycle c+9, with `done` high and `top_code` valid from that cycle. IDLE follows at c+10.
- **Minimum window latency:** WINDOW + 10 cycles from `start` to `done`, with `code_valid` held high.
- **Counter visibility:** a counter incremented at edge e is visible on `rd_cnt` at edge e+1 if `rd_idx` selects it.
- **Simultaneous events:**
  - `start` with `code_valid` in IDLE: the sample is dropped.
  - `code_valid` on the last COUNT edge: counted. Further samples in SCAN and DONE are ignored.

## Structure

- **Package `code_tally_pkg`:**
  - FSM state typedef and encoding.
  - `NUM_CODES`=8.
  - `CODE_MIN`=1, `CODE_MAX`=8.
  - `SCAN_LEN`=8.
- **Sub-module `sat_counter`** (CNT_W wide; `clr`, `inc`, `q` ports): instantiated 9 times, once per legal code plus one for `err_cnt`.
- **Top level:** FSM, sample counter, scan comparator and read mux.

## Test plan

- **Reset mid-COUNT:** `start`, then 5 samples of code 3, then assert `rst_n`=0. Expect all outputs 0, state IDLE, and no `done`.
- **Mixed window:** WINDOW=16 with 8×code 2, 5×code 7, 3×code 0. Expect counter[1]=8, counter[6]=5, `err_cnt`=3, `top_code`=2, and `done` exactly 26 cycles after `start`.
- **Tie:** WINDOW=4 with codes 5, 3, 5, 3. Expect `top_code`=3.
- **All invalid:** WINDOW=4 with codes 0, 9, 15, 12. Expect `err_cnt`=4, all counters 0, `top_code`=0.
- **Saturation:** CNT_W=2, WINDOW=3, code 1 ×3. Expect counter[0]=3. Then CNT_W=2, WINDOW=3 with 3 invalid codes. Expect `err_cnt`=3 with no wrap. Also WINDOW=3 with code_valid gaps: expect `done` to be delayed by the number of idle cycles.
- **Ignored start:** pulse `start` during SCAN. Expect no second window. A subsequent `start` in IDLE clears the counters in CLEAR.
